// File: rtl/dzcpu_useq_pkg.sv
// Shared encodings for the dzcpu microcode sequencer: branch ops, flow states
// and sticky error bit positions.
package dzcpu_useq_pkg;

    typedef enum logic [2:0] {
        ubr_next = 3'd0,
        ubr_jmp  = 3'd1,
        ubr_jc   = 3'd2,
        ubr_call = 3'd3,
        ubr_ret  = 3'd4,
        ubr_disp = 3'd5,
        ubr_end  = 3'd6,
        ubr_endc = 3'd7
    } ubr_op_e;

    typedef enum logic [1:0] {
        USEQ_IDLE  = 2'd0,
        USEQ_RUN   = 2'd1,
        USEQ_STALL = 2'd2,
        USEQ_DONE  = 2'd3
    } useq_state_e;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_TMO = 2;

    // Polarity-qualified condition: act when the flag matches the requested level.
    function automatic logic cond_act(input logic flag, input logic pol);
        return flag ~^ pol;
    endfunction

endpackage

// File: rtl/dzcpu_ustack.sv
// Micro-call return stack. Shift-register LIFO: the top entry always sits in
// slot 0, so no address arithmetic is needed on push or pop.
module dzcpu_ustack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0] count_r;

    assign full     = (count_r == CNT_W'(DEPTH));
    assign empty    = (count_r == '0);
    assign count    = count_r;
    assign top_data = mem_r[0];

    // occupancy counter
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_r <= '0;
        end else if (push && !full) begin
            count_r <= count_r + CNT_W'(1);
        end else if (pop && !empty) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // entry storage, shifts down on push and up on pop
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem_r[0] <= push_data;
            for (int i = 1; i < DEPTH; i++) begin
                mem_r[i] <= mem_r[i-1];
            end
        end else if (pop && !empty) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_r[i] <= mem_r[i+1];
            end
        end
    end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: drives the uPC, gates datapath writes, handles
// micro-calls, conditional branches/ends and memory wait-state stalls.
module dzcpu_useq
    import dzcpu_useq_pkg::*;
#(
    parameter int UPC_W       = 8,
    parameter int COND_W      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int MAX_WAIT    = 15,
    localparam int CSEL_W  = (COND_W > 1) ? $clog2(COND_W) : 1,
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1),
    localparam int WAIT_W  = $clog2(MAX_WAIT + 1)
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iStart,
    input  logic [UPC_W-1:0]   iEntry,
    input  logic [UPC_W-1:0]   iDispatchIdx,
    input  logic [2:0]         iUopBrOp,
    input  logic [UPC_W-1:0]   iUopTarget,
    input  logic [CSEL_W-1:0]  iUopCondSel,
    input  logic               iUopCondPol,
    input  logic [COND_W-1:0]  iCond,
    input  logic               iUopMemReq,
    input  logic               iMemReady,
    output logic [UPC_W-1:0]   oUpc,
    output logic               oUopValid,
    output logic               oEof,
    output logic               oAbort,
    output logic               oBusy,
    output logic [2:0]         oErr,
    output logic [DEPTH_W-1:0] oDepth
);

    useq_state_e       state_r, state_n;
    logic [UPC_W-1:0]  upc_r, upc_n, upc_inc_s, top_s;
    logic [WAIT_W-1:0] cnt_r, cnt_n;
    logic [2:0]        err_r, err_n;
    logic              eof_r, eof_n, abort_r, abort_n, busy_r;
    logic              exec_s, flag_s, cond_s, push_s, pop_s, clr_s, full_s, empty_s;
    ubr_op_e           op_s;

    assign op_s      = ubr_op_e'(iUopBrOp);
    assign upc_inc_s = upc_r + UPC_W'(1);
    assign exec_s    = ((state_r == USEQ_RUN) || (state_r == USEQ_STALL)) &&
                       !(iUopMemReq && !iMemReady);
    assign cond_s    = cond_act(flag_s, iUopCondPol);

    // condition select; indices past the last flag read as constant 0
    always_comb begin
        flag_s = 1'b0;
        if (int'(iUopCondSel) < COND_W) begin
            flag_s = iCond[iUopCondSel];
        end else begin
            flag_s = 1'b0;
        end
    end

    dzcpu_ustack #(
        .WIDTH (UPC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock     (iClock),
        .reset     (iReset),
        .clear     (clr_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (upc_inc_s),
        .top_data  (top_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (oDepth)
    );

    // next-state, uPC and error decode
    always_comb begin
        state_n = state_r;
        upc_n   = upc_r;
        cnt_n   = cnt_r;
        err_n   = err_r;
        eof_n   = 1'b0;
        abort_n = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        clr_s   = 1'b0;
        case (state_r)
            USEQ_IDLE: begin
                if (iStart) begin
                    upc_n   = iEntry;
                    err_n   = 3'b000;
                    cnt_n   = '0;
                    clr_s   = 1'b1;
                    state_n = USEQ_RUN;
                end else begin
                    state_n = USEQ_IDLE;
                end
            end
            USEQ_RUN, USEQ_STALL: begin
                if (exec_s) begin
                    cnt_n   = '0;
                    state_n = USEQ_RUN;
                    case (op_s)
                        ubr_next: upc_n = upc_inc_s;
                        ubr_jmp:  upc_n = iUopTarget;
                        ubr_jc:   upc_n = cond_s ? iUopTarget : upc_inc_s;
                        ubr_call: begin
                            if (full_s) begin
                                err_n[ERR_OVF] = 1'b1;
                                abort_n        = 1'b1;
                                state_n        = USEQ_IDLE;
                            end else begin
                                push_s = 1'b1;
                                upc_n  = iUopTarget;
                            end
                        end
                        ubr_ret: begin
                            if (empty_s) begin
                                err_n[ERR_UNF] = 1'b1;
                                abort_n        = 1'b1;
                                state_n        = USEQ_IDLE;
                            end else begin
                                pop_s = 1'b1;
                                upc_n = top_s;
                            end
                        end
                        ubr_disp: upc_n = iDispatchIdx;
                        ubr_end: begin
                            eof_n   = 1'b1;
                            state_n = USEQ_DONE;
                        end
                        ubr_endc: begin
                            if (cond_s) begin
                                eof_n   = 1'b1;
                                state_n = USEQ_DONE;
                            end else begin
                                upc_n = upc_inc_s;
                            end
                        end
                        default: upc_n = upc_inc_s;
                    endcase
                end else if ((state_r == USEQ_RUN) && (MAX_WAIT > 1)) begin
                    cnt_n   = WAIT_W'(1);
                    state_n = USEQ_STALL;
                end else if ((state_r == USEQ_STALL) && (int'(cnt_r) + 1 < MAX_WAIT)) begin
                    cnt_n = cnt_r + WAIT_W'(1);
                end else begin
                    err_n[ERR_TMO] = 1'b1;
                    abort_n        = 1'b1;
                    cnt_n          = '0;
                    state_n        = USEQ_IDLE;
                end
            end
            USEQ_DONE: begin
                clr_s   = 1'b1;
                state_n = USEQ_IDLE;
            end
            default: state_n = USEQ_IDLE;
        endcase
    end

    // sequencer state and registered outputs
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_r <= USEQ_IDLE;
            upc_r   <= '0;
            cnt_r   <= '0;
            err_r   <= 3'b000;
            eof_r   <= 1'b0;
            abort_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            upc_r   <= upc_n;
            cnt_r   <= cnt_n;
            err_r   <= err_n;
            eof_r   <= eof_n;
            abort_r <= abort_n;
            busy_r  <= (state_n != USEQ_IDLE);
        end
    end

    assign oUpc      = upc_r;
    assign oUopValid = exec_s;
    assign oEof      = eof_r;
    assign oAbort    = abort_r;
    assign oBusy     = busy_r;
    assign oErr      = err_r;

endmodule
